// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU shifters: the FSM state type and the datapath
// sizing constants used by the sequential left shifter.
package alu_shift_pkg;

    localparam int SHIFT_WIDTH  = 32;
    localparam int SHIFT_STAGES = 5;
    localparam int STG_W        = 3;

    // The stage index of the final shift step (stage 4 applies a shift of 16).
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(SHIFT_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

endpackage

// File: rtl/lshift_stage.sv
// One selectable power-of-two left-shift step: out = in << (1 << stage) when en,
// else in. Built as a cascade of 2:1 muxes, one per possible stage.
module lshift_stage
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    input  logic [STG_W-1:0] stage,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] lvl [SHIFT_STAGES+1];

    assign lvl[0] = in;

    // At most one mux in the chain is enabled, so only one shift is ever applied.
    for (genvar k = 0; k < SHIFT_STAGES; k++) begin : gen_lvl
        localparam int AMT = 1 << k;
        assign lvl[k+1] = (en && (stage == STG_W'(k))) ? (lvl[k] << AMT) : lvl[k];
    end

    assign out = lvl[SHIFT_STAGES];

endmodule

// File: rtl/left_shift_iter.sv
// Sequential logical left shifter: one power-of-two stage per clock, fixed
// six-cycle latency, start/busy/result_rdy handshake like the mul/div unit.
module left_shift_iter
    import alu_shift_pkg::*;
#(
    parameter int WIDTH  = SHIFT_WIDTH,
    parameter int STAGES = SHIFT_STAGES
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  data,
    input  logic [STAGES-1:0] shamt,
    output logic              busy,
    output logic              result_rdy,
    output logic [WIDTH-1:0]  out
);

    shift_state_t      state, next_state;
    logic [WIDTH-1:0]  acc;
    logic [STAGES-1:0] sh;
    logic [STG_W-1:0]  stg;
    logic [WIDTH-1:0]  out_q;
    logic [WIDTH-1:0]  stage_out;

    // A single stage instance is reused every cycle, selected by the counter.
    lshift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .in    (acc),
        .stage (stg),
        .en    (sh[stg]),
        .out   (stage_out)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (stg == LAST_STG) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            sh    <= '0;
            stg   <= '0;
            out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= data;
                        sh  <= shamt;
                        stg <= '0;
                    end
                end
                SHIFT: begin
                    acc <= stage_out;
                    stg <= stg + STG_W'(1);
                    // The last stage bypasses acc so out is ready on DONE entry.
                    if (stg == LAST_STG) out_q <= stage_out;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign result_rdy = (state == DONE);
    assign out        = out_q;

endmodule

// File: tb/tb_left_shift_iter.sv
// Randomized and directed bench for left_shift_iter, checked every cycle
// against a timeline model of accept/latency/result.
module tb_left_shift_iter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data = '0;
    logic [4:0]  shamt = '0;
    logic        busy;
    logic        result_rdy;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: edges elapsed since the last accepted start (-1 = idle).
    int          since = -1;
    logic [31:0] pending = '0;
    logic [31:0] exp_out = '0;

    left_shift_iter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .data       (data),
        .shamt      (shamt),
        .busy       (busy),
        .result_rdy (result_rdy),
        .out        (out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic bit m_busy();
        return (since >= 0) && (since <= 5);
    endfunction

    always @(negedge reset_n) begin
        since   = -1;
        exp_out = '0;
    end

    always @(posedge clock) begin
        if (reset_n) begin
            bit was_busy;
            was_busy = m_busy();
            if (since >= 0) since++;
            if (since > 5) since = -1;
            if (!was_busy && start) begin
                since   = 0;
                pending = data << shamt;
            end
            if (since == 5) exp_out = pending;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy()});
            chk("result_rdy", {31'd0, result_rdy}, {31'd0, since == 5});
            chk("out", out, exp_out);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        if (busy) chk({nm, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [31:0] d, input logic [4:0] s,
                          input logic [31:0] req, input string nm);
        int lat = 0;
        int bcnt = 0;
        bit seen = 1'b0;
        start = 1'b1; data = d; shamt = s;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (busy) bcnt++;
            if (result_rdy && !seen) begin
                seen = 1'b1;
                lat  = i;
                chk({nm, "_out"}, out, req);
            end
            if (!busy) break;
        end
        chk({nm, "_latency"}, lat, 32'd6);
        chk({nm, "_busy_cycles"}, bcnt, 32'd6);
        tick();
    endtask

    initial begin
        int rdy_t [2];
        int nrdy;
        bit bad_rdy;

        repeat (2) tick();
        chk_en = 1'b1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rdy", {31'd0, result_rdy}, 32'd0);
        chk("reset_out", out, 32'd0);
        reset_n = 1'b1;
        tick();

        run_op(32'h0000_0001, 5'd31, 32'h8000_0000, "msb");
        run_op(32'h8000_0001, 5'd1,  32'h0000_0002, "drop");
        run_op(32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "zero");

        // Start pulses during SHIFT and DONE must be ignored.
        start = 1'b1; data = 32'h0000_00FF; shamt = 5'd4;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; data = 32'h1; shamt = 5'd8;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("ignore_out", out, 32'h0000_0FF0);
        chk("ignore_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; data = 32'h1; shamt = 5'd8;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("hold_out", out, 32'h0000_0FF0);
        wait_idle("hold");
        chk("next_out", out, 32'h0000_0100);
        tick();

        // Reset during the third SHIFT cycle.
        start = 1'b1; data = 32'h1; shamt = 5'd16;
        tick();
        start = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdy", {31'd0, result_rdy}, 32'd0);
        chk("rst_out", out, 32'd0);
        tick();
        reset_n = 1'b1;
        bad_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (result_rdy) bad_rdy = 1'b1;
        end
        chk("rst_no_rdy", {31'd0, bad_rdy}, 32'd0);
        tick();
        run_op(32'h3, 5'd2, 32'h0000_000C, "after_rst");

        // start held continuously: accepts at E0 and E7.
        start = 1'b1; data = 32'h1; shamt = 5'd5;
        nrdy = 0;
        rdy_t[0] = 0; rdy_t[1] = 0;
        for (int i = 1; i <= 40 && nrdy < 2; i++) begin
            @(negedge clock);
            if (result_rdy) begin
                rdy_t[nrdy] = i;
                nrdy++;
                chk("b2b_out", out, 32'h0000_0020);
            end
        end
        tick();
        start = 1'b0;
        chk("b2b_count", nrdy, 32'd2);
        chk("b2b_spacing", rdy_t[1] - rdy_t[0], 32'd7);
        wait_idle("b2b");
        tick();

        // Randomized operations with stray start pulses while busy.
        for (int n = 0; n < 40; n++) begin
            int gap = $urandom_range(0, 3);
            int hold = $urandom_range(1, 9);
            repeat (gap) tick();
            for (int h = 0; h < hold; h++) begin
                start = 1'b1;
                data  = $urandom;
                shamt = 5'($urandom_range(0, 31));
                tick();
                start = ($urandom_range(0, 1) == 1);
            end
            start = 1'b0;
            if ($urandom_range(0, 3) == 0) wait_idle("rand");
        end
        wait_idle("final");
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/left_shift_iter.md
# left_shift_iter

Sequential logical left shifter: the left-shifting counterpart to the combinational arithmetic right shifter in the ALU. It accepts a 32-bit operand and 5-bit shift amount on a single-cycle `start` pulse and applies one power-of-two shift stage per clock (1, 2, 4, 8, 16). It returns the zero-filled result with a one-cycle `result_rdy` pulse. It sits beside the multicycle multiply/divide unit and uses the same start/busy/ready handshake style, so the processor stalls on `busy`.

## Interface
- `WIDTH`, 32: operand/result width; only 32 is supported.
- `STAGES`, 5: number of shift stages, equal to the width of `shamt`; fixed at $clog2(WIDTH).

- `clock`  input  1  single clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only when `busy`=0.
- `data`  input  32  operand; captured on the accepting edge.
- `shamt`  input  5  shift amount; captured on the accepting edge.
- `busy`  output  1  high while an operation is in flight or completing.
- `result_rdy`  output  1  one-cycle pulse; `out` is valid.
- `out`  output  32  registered result; holds the last result.

## Operation
- Internal state:
  - FSM states: IDLE, SHIFT, DONE.
  - Accumulator `acc[31:0]`.
  - Latched shift amount `sh[4:0]`.
  - Stage counter `stg[2:0]`.
  - Result register driving `out`.
- IDLE:
  - If `start`=1: `acc`←`data`, `sh`←`shamt`, `stg`←0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - If `sh[stg]`=1, `acc`←`acc` << (1<<`stg`), zero fill, MSBs discarded; otherwise `acc` is unchanged.
  - `stg`←`stg`+1.
  - When `stg`==4 on this edge, write the shifted value directly into the `out` register and go to DONE.
- DONE: `result_rdy`=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- `busy` = (state != IDLE).
- `start` while `busy`=1, including during DONE, is ignored; there is no queuing and no error flag.
- `shamt`=0 still takes the full latency and returns `out`=`data`.
- No early exit: latency is independent of `shamt`.
- `out` changes only on the DONE-entry edge and is stable at all other times, including during a following operation.
- Reset (`reset_n`=0, at any time, including mid-SHIFT):
  - state=IDLE, `busy`=0, `result_rdy`=0, `out`=0, `acc`=0, `sh`=0, `stg`=0.
  - The in-flight operation is discarded.
  - On release, the first `start` is accepted normally.

## Timing
- Edge E0: `start` accepted.
- Edges E1–E5: stages 0–4 applied.
  - E5 loads `out`.
  - `result_rdy` is high in the cycle after E5.
  - The state returns to IDLE at E6.
- `busy` is high from after E0 until after E6 (6 cycles).
- Earliest next accept is E7 (`start` held or re-asserted after `busy` falls).
- Result latency: 6 cycles from the accepting edge to the `result_rdy` cycle, inclusive of DONE.
- Reset assertion takes effect immediately (asynchronous).
- Deassertion is assumed synchronized upstream; the first active edge after release sees IDLE.

## Structure
- Shared package `alu_shift_pkg`:
  - state enum `shift_state_t` {IDLE, SHIFT, DONE};
  - constants `SHIFT_WIDTH`=32, `SHIFT_STAGES`=5.
- One natural sub-module, `lshift_stage`:
  - combinational, ports `in[31:0]`, `stage[2:0]`, `en`, `out[31:0]`;
  - computes `in` << (1<<`stage`) when `en`, else passes `in` through;
  - built from 2:1 muxes like the existing shifters.
- The top contains the FSM, counter, registers and a single `lshift_stage` instance shared across cycles.

## Test plan
- `data`=0x0000_0001, `shamt`=31, `start` pulse:
  - `busy` high for 6 cycles;
  - `result_rdy` high exactly one cycle, 6 cycles after accept;
  - `out`=0x8000_0000.
- `data`=0x8000_0001, `shamt`=1 → `out`=0x0000_0002 (MSB dropped, zero fill, no sign extension).
- `data`=0xDEAD_BEEF, `shamt`=0 → `out`=0xDEAD_BEEF with the same 6-cycle latency.
- Mid-operation `start` and `out` stability:
  - accept `data`=0x0000_00FF, `shamt`=4;
  - re-pulse `start` with `data`=0x1, `shamt`=8 during SHIFT and during DONE;
  - required: both pulses ignored, `out`=0x0000_0FF0, `out` unchanged until the next accepted operation completes.
- Reset mid-operation:
  - `reset_n` low for 1 cycle at the 3rd SHIFT cycle of (0x1, 16);
  - required: `busy`, `result_rdy` and `out` all 0 immediately, no `result_rdy` follows;
  - a subsequent (0x3, 2) yields `out`=0x0000_000C.
- Back-to-back: keep `start` high continuously with (0x1, 5) → accepts at E0 and E7, `out`=0x0000_0020 twice, two `result_rdy` pulses 7 cycles apart.
